// File: rtl/button_event_classifier_pkg.sv
// button_event_classifier_pkg: state encoding and default timing shared by the button blocks
package btn_pkg;
  typedef enum logic [1:0] {WAIT_REL, IDLE, PRESSED, LONG} btn_state_t;
  localparam int LONG_TIME_DEF = 3000;
  localparam int REPEAT_TIME_DEF = 500;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/button_event_classifier_if.sv
// button_event_classifier_if: button level in, classified events out
interface button_event_classifier_if;
  logic btn_db;
  logic enable;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic held;
  logic repeat_pulse;
  modport master (output btn_db, enable, input press_pulse, short_pulse, long_pulse, held, repeat_pulse);
  modport slave (input btn_db, enable, output press_pulse, short_pulse, long_pulse, held, repeat_pulse);
endinterface

// File: rtl/button_event_classifier_press_timer.sv
// press_timer: hold counter with clear, load-one, increment and terminal compare
module press_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         start,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (start) cnt <= W'(1);
    else if (inc) cnt <= cnt + 1'b1;
  assign hit = cnt == limit;
endmodule

// File: rtl/button_event_classifier.sv
// button_event_classifier: debounced level to press/short/long/repeat events.
// Auto-repeat in LONG is compiled in with BUTTON_AUTO_REPEAT_EN.
module button_event_classifier
  import btn_pkg::*;
#(
  parameter int LONG_TIME = LONG_TIME_DEF,
  parameter int REPEAT_TIME = REPEAT_TIME_DEF
) (
  input logic clk,
  input logic rst,
  button_event_classifier_if.slave bus
);
  localparam int W = $clog2(max2(LONG_TIME, REPEAT_TIME) + 1);
  btn_state_t state, nxt;
  logic clr, start, inc, hit;
  logic p_n, s_n, l_n, r_n;
  logic p_q, s_q, l_q, r_q, h_q;
  logic [W-1:0] limit;
`ifdef BUTTON_AUTO_REPEAT_EN
  assign limit = (state == LONG) ? W'(REPEAT_TIME - 1) : W'(LONG_TIME - 1);
`else
  assign limit = W'(LONG_TIME - 1);
`endif
  press_timer #(.W(W)) timer (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .inc(inc), .limit(limit), .hit(hit)
  );
  // enable beats release, release beats threshold
  always_comb begin
    nxt = state;
    clr = 1'b0;
    start = 1'b0;
    inc = 1'b0;
    p_n = 1'b0;
    s_n = 1'b0;
    l_n = 1'b0;
    r_n = 1'b0;
    case (state)
      WAIT_REL: if (!bus.btn_db) nxt = IDLE;
      IDLE: if (bus.enable && bus.btn_db) begin
        nxt = PRESSED;
        p_n = 1'b1;
        start = 1'b1;
      end
      PRESSED: if (!bus.enable) begin
        nxt = WAIT_REL;
        clr = 1'b1;
      end else if (!bus.btn_db) begin
        nxt = IDLE;
        s_n = 1'b1;
        clr = 1'b1;
      end else if (hit) begin
        nxt = LONG;
        l_n = 1'b1;
        clr = 1'b1;
      end else inc = 1'b1;
      default: if (!bus.enable) begin
        nxt = WAIT_REL;
        clr = 1'b1;
      end else if (!bus.btn_db) begin
        nxt = IDLE;
        clr = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
      end else if (hit) begin
        r_n = 1'b1;
        clr = 1'b1;
      end else inc = 1'b1;
`else
      end
`endif
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= WAIT_REL;
      {p_q, s_q, l_q, r_q, h_q} <= '0;
    end else begin
      state <= nxt;
      {p_q, s_q, l_q, r_q} <= {p_n, s_n, l_n, r_n};
      h_q <= nxt == LONG;
    end
  assign bus.press_pulse = p_q;
  assign bus.short_pulse = s_q;
  assign bus.long_pulse = l_q;
  assign bus.repeat_pulse = r_q;
  assign bus.held = h_q;
endmodule

// File: tb/tb_button_event_classifier.sv
// tb_button_event_classifier: directed and random button traffic against a run-length model
module tb_button_event_classifier;
  localparam int L = 10;
  localparam int R = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  button_event_classifier_if bus ();
  button_event_classifier #(.LONG_TIME(L), .REPEAT_TIME(R)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int vecs = 0;
  int errs = 0;
  int h = 0;
  bit need_low = 1'b1;
  bit ep, es, el, er;
  task automatic chk(input string tag, input logic o, input logic e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, o, e, $time);
    end
  endtask
  task automatic check_all(input logic p, input logic s, input logic l, input logic r, input logic hd);
    chk("press_pulse", bus.press_pulse, p);
    chk("short_pulse", bus.short_pulse, s);
    chk("long_pulse", bus.long_pulse, l);
    chk("repeat_pulse", bus.repeat_pulse, r);
    chk("held", bus.held, hd);
  endtask
  // h is the length of the accepted press so far; need_low means a release must be seen first
  task automatic model(input bit b, input bit en);
    {ep, es, el, er} = '0;
    if (h > 0) begin
      if (!en) begin
        h = 0;
        need_low = 1'b1;
      end else if (!b) begin
        es = h < L;
        h = 0;
      end else begin
        h++;
        el = h == L;
`ifdef BUTTON_AUTO_REPEAT_EN
        er = (h > L) && ((h - L) % R == 0);
`endif
      end
    end else if (need_low) need_low = b;
    else if (en && b) begin
      ep = 1'b1;
      h = 1;
    end
  endtask
  task automatic step(input bit b, input bit en);
    bus.btn_db = b;
    bus.enable = en;
    @(posedge clk);
    model(b, en);
    @(negedge clk);
    check_all(ep, es, el, er, h >= L);
  endtask
  task automatic run(input bit b, input bit en, input int n);
    for (int i = 0; i < n; i++) step(b, en);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #2;
    h = 0;
    need_low = 1'b1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
  endtask
  initial begin
    bus.btn_db = 1'b1;
    bus.enable = 1'b1;
    rst = 1'b0;
    #1 check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    run(1, 1, 20);
    run(0, 1, 2);
    run(1, 1, 5);
    run(0, 1, 3);
    run(1, 1, 9);
    run(0, 1, 2);
    run(1, 1, 10);
    run(0, 1, 2);
    run(1, 1, 22);
    run(0, 1, 3);
    run(1, 1, 5);
    step(1, 0);
    run(1, 1, 3);
    run(0, 1, 2);
    run(1, 1, 2);
    step(0, 0);
    step(0, 1);
    run(1, 1, 3);
    step(0, 1);
    run(1, 1, 3);
    run(0, 1, 2);
    run(1, 1, 12);
    @(negedge clk) do_reset();
    run(1, 1, 4);
    run(0, 1, 1);
    for (int k = 0; k < 40; k++) begin
      int len;
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) step(k[0] ? 1'b0 : 1'b1, $urandom_range(0, 19) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
